led_pio_scheduler: RTL and testbench
====================================

LED_PIO_SCHEDULER -- requirements
Module: led_pio_scheduler

Interface
REQ-001 Parameter HOLD_CYCLES, default 50000000, number of clk cycles an event pattern stays on the LEDs; legal range 1..2^26-1.
REQ-002 clk  in  1  system clock; all state changes on the rising edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 sw_req  in  1  software pattern request, single-cycle strobe.
REQ-005 sw_data  in  4  software pattern, valid while sw_req=1.
REQ-006 ev_req  in  1  hardware event request (SD activity/error), single-cycle strobe.
REQ-007 ev_data  in  4  event pattern, valid while ev_req=1.
REQ-008 m_address  out  2  Avalon-MM master address to the LED PIO slave; always 0.
REQ-009 m_chipselect  out  1  Avalon-MM chipselect to the LED PIO slave.
REQ-010 m_write_n  out  1  Avalon-MM write strobe, active-low.
REQ-011 m_writedata  out  32  {28'b0, pattern}.
REQ-012 shown  out  4  copy of the last pattern written to the PIO.
REQ-013 busy  out  1  1 whenever state is not IDLE.

Function
REQ-014 The block shall implement the states IDLE, WR_SW, WR_EV, HOLD and RESTORE.
REQ-015 A PIO write shall occupy exactly one cycle: m_chipselect=1, m_write_n=0, m_address=0; no waitrequest. In all other cycles m_chipselect=0 and m_write_n=1.
REQ-016 Write cycles shall be WR_SW (writes shadow), WR_EV (writes the latched event pattern) and RESTORE (writes shadow); shown shall update in the same cycle as each write.
REQ-017 An sw_req in any state shall load sw_data into the 4-bit shadow register and set sw_pend.
REQ-018 sw_pend shall clear on the WR_SW and RESTORE write cycles; an sw_req arriving in the same cycle shall win, leaving sw_pend=1 with the new shadow.
REQ-019 An ev_req in any state shall load ev_data into the event register.
REQ-020 Next-state rule from IDLE, WR_SW and RESTORE: ev_req -> WR_EV; else sw_pend (after the REQ-018 update) -> WR_SW; else IDLE.
REQ-021 WR_EV -> WR_EV if ev_req; else HOLD with the hold counter loaded with HOLD_CYCLES-1.
REQ-022 HOLD: ev_req -> WR_EV (retrigger); else counter=0 -> RESTORE; else decrement. sw_req in HOLD only updates shadow; no PIO write.
REQ-023 Latency: a strobe sampled on edge N shall produce its write cycle between edges N and N+1. A lone event shall be followed by exactly HOLD_CYCLES HOLD cycles and then one RESTORE cycle.
REQ-024 Simultaneous sw_req and ev_req: the event shall be written first; the new software pattern shall appear at RESTORE.
REQ-025 RESTORE shall write the shadow even if sw_pend=0, so the software pattern always returns after an event.

Reset
REQ-026 While reset_n=0: state IDLE; shadow, event register, sw_pend, hold counter, shown, m_address and m_writedata = 0; m_chipselect=0; m_write_n=1; busy=0.
REQ-027 Reset asserted mid-write or mid-HOLD shall abort immediately; the block shall issue no write after release until a new strobe arrives.

Verification (HOLD_CYCLES=4)
REQ-028 Reset, then sw_req with sw_data=0xA -> one write cycle with m_writedata=0x0000000A on the next edge, shown=0xA, busy=0 the cycle after.
REQ-029 Shadow=0xA, ev_req with ev_data=0x5 -> write 0x5; 4 HOLD cycles; RESTORE writes 0xA; then IDLE.
REQ-030 sw_req=1 and ev_req=1 in the same cycle (0x3 and 0xC) -> write 0xC; HOLD 4; RESTORE writes 0x3; no separate WR_SW cycle.
REQ-031 ev_req 0x1, then ev_req 0x2 in the 3rd HOLD cycle -> write 0x2; hold restarts with full 4 cycles; exactly one RESTORE.
REQ-032 sw_req 0x7 during HOLD -> no write until RESTORE, which writes 0x7; sw_pend clear afterwards, so no extra WR_SW.
REQ-033 reset_n pulsed low during HOLD -> all outputs at reset values; no write cycle after release.

Source files
------------

// File: rtl/led_pio_scheduler.sv
// led_pio_scheduler
//   Arbitrates software LED patterns against hardware event patterns and drives
//   a 4-bit LED PIO slave over a write-only Avalon-MM master. An event pattern
//   is shown for HOLD_CYCLES cycles. After that the software pattern (shadow)
//   is written back.
// Ports
//   clk, reset_n          clock, async active-low reset
//   sw_req / sw_data      software pattern strobe + data
//   ev_req / ev_data      hardware event strobe + data
//   m_address, m_chipselect, m_write_n, m_writedata   Avalon-MM master (no waitrequest)
//   shown                 last pattern written to the PIO
//   busy                  high whenever the FSM is not IDLE
module led_pio_scheduler #(
  parameter int unsigned HOLD_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sw_req,
  input  logic [3:0]  sw_data,
  input  logic        ev_req,
  input  logic [3:0]  ev_data,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  output logic [3:0]  shown,
  output logic        busy
);

  localparam int CW = 26;

  typedef enum logic [2:0] {IDLE, WR_SW, WR_EV, HOLD, RESTORE} state_t;

  state_t          state, state_nxt;
  logic [3:0]      shadow, shadow_nxt;
  logic [3:0]      ev_reg, ev_nxt;
  logic            sw_pend, sw_pend_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [3:0]      pat_nxt;
  logic            wr_nxt;
  logic            wr_cur;

  assign wr_cur = (state == WR_SW) || (state == WR_EV) || (state == RESTORE);

  always_comb begin
    shadow_nxt  = sw_req ? sw_data : shadow;
    ev_nxt      = ev_req ? ev_data : ev_reg;
    // A strobe landing in a clearing write cycle wins over the clear.
    sw_pend_nxt = sw_req | (sw_pend & ~((state == WR_SW) || (state == RESTORE)));
    state_nxt   = state;
    cnt_nxt     = cnt;
    case (state)
      IDLE, WR_SW, RESTORE: begin
        if (ev_req)           state_nxt = WR_EV;
        else if (sw_pend_nxt) state_nxt = WR_SW;
        else                  state_nxt = IDLE;
      end
      WR_EV: begin
        if (ev_req) state_nxt = WR_EV;
        else begin
          state_nxt = HOLD;
          cnt_nxt   = CW'(HOLD_CYCLES - 1);
        end
      end
      HOLD: begin
        if (ev_req)          state_nxt = WR_EV;
        else if (cnt == '0)  state_nxt = RESTORE;
        else                 cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    wr_nxt  = (state_nxt == WR_SW) || (state_nxt == WR_EV) || (state_nxt == RESTORE);
    pat_nxt = (state_nxt == WR_EV) ? ev_nxt : shadow_nxt;
  end

  // shown is loaded on the edge that enters a write state, so it changes in
  // the same cycle the PIO sees the write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      shadow  <= '0;
      ev_reg  <= '0;
      sw_pend <= 1'b0;
      cnt     <= '0;
      shown   <= '0;
    end else begin
      state   <= state_nxt;
      shadow  <= shadow_nxt;
      ev_reg  <= ev_nxt;
      sw_pend <= sw_pend_nxt;
      cnt     <= cnt_nxt;
      if (wr_nxt) shown <= pat_nxt;
    end
  end

  assign m_address    = 2'b00;
  assign m_chipselect = wr_cur;
  assign m_write_n    = ~wr_cur;
  assign m_writedata  = {28'b0, shown};
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_led_pio_scheduler.sv
module tb_led_pio_scheduler;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sw_req = 1'b0, ev_req = 1'b0;
  logic [3:0]  sw_data = '0, ev_data = '0;
  logic [1:0]  m_address;
  logic        m_chipselect, m_write_n, busy;
  logic [31:0] m_writedata;
  logic [3:0]  shown;

  int n_vec = 0;
  int n_bad = 0;

  led_pio_scheduler #(.HOLD_CYCLES(H)) dut (
    .clk(clk), .reset_n(reset_n),
    .sw_req(sw_req), .sw_data(sw_data), .ev_req(ev_req), .ev_data(ev_data),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .shown(shown), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string    name;
    bit       rst_n;
    bit       swr;
    bit [3:0] swd;
    bit       evr;
    bit [3:0] evd;
    bit       cs;
    bit [3:0] shw;
    bit       bsy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input bit r, input bit sr, input bit [3:0] sd,
                     input bit er, input bit [3:0] ed, input bit c, input bit [3:0] s,
                     input bit b);
    vec_t v;
    v.name = nm; v.rst_n = r; v.swr = sr; v.swd = sd; v.evr = er; v.evd = ed;
    v.cs = c; v.shw = s; v.bsy = b;
    tbl.push_back(v);
  endtask

  // Called at a falling edge: drive inputs, let one rising edge pass, then
  // compare outputs at the next falling edge.
  task automatic step(input string nm, input bit r, input bit sr, input bit [3:0] sd,
                      input bit er, input bit [3:0] ed, input bit c, input bit [3:0] s,
                      input bit b);
    logic [40:0] got, exp;
    reset_n = r; sw_req = sr; sw_data = sd; ev_req = er; ev_data = ed;
    @(posedge clk);
    @(negedge clk);
    got = {m_chipselect, m_write_n, m_address, m_writedata, shown, busy};
    exp = {c, ~c, 2'b00, 28'b0, s, s, b};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got cs=%b wn=%b addr=%0d wdata=%h shown=%h busy=%b, want cs=%b wn=%b addr=0 wdata=%h shown=%h busy=%b",
               nm, $time, m_chipselect, m_write_n, m_address, m_writedata, shown, busy,
               c, ~c, {28'b0, s}, s, b);
    end
  endtask

  // Reference model: events restart a timer of H idle cycles followed by one
  // restore write; otherwise any outstanding software request is written.
  bit       md_pend, md_in_ev;
  bit [3:0] md_sh, md_shown;
  int       md_until, md_kind; // kind: 0 none, 1 sw write, 2 event write, 3 restore

  task automatic model(input bit r, input bit sr, input bit [3:0] sd,
                       input bit er, input bit [3:0] ed,
                       output bit c, output bit [3:0] s, output bit b);
    bit pn;
    if (!r) begin
      md_pend = 0; md_in_ev = 0; md_sh = 0; md_shown = 0; md_until = 0; md_kind = 0;
    end else begin
      pn = sr ? 1'b1 : ((md_kind == 1 || md_kind == 3) ? 1'b0 : md_pend);
      if (sr) md_sh = sd;
      if (er) begin
        md_kind = 2; md_shown = ed; md_in_ev = 1; md_until = H;
      end else if (md_in_ev) begin
        if (md_until == 0) begin
          md_kind = 3; md_shown = md_sh; md_in_ev = 0;
        end else begin
          md_until--; md_kind = 0;
        end
      end else if (pn) begin
        md_kind = 1; md_shown = md_sh;
      end else md_kind = 0;
      md_pend = pn;
    end
    c = (md_kind != 0);
    s = md_shown;
    b = (md_kind != 0) || md_in_ev;
  endtask

  initial begin
    bit       r, sr, er, c, b;
    bit [3:0] sd, ed, s;

    add("reset", 0,0,0,0,0, 0,0,0);
    add("idle",  1,0,0,0,0, 0,0,0);
    // single software write
    add("sw_wr",   1,1,4'hA,0,0, 1,4'hA,1);
    add("sw_done", 1,0,0,0,0,    0,4'hA,0);
    // lone event
    add("ev_wr", 1,0,0,1,4'h5, 1,4'h5,1);
    repeat (H) add("ev_hold", 1,0,0,0,0, 0,4'h5,1);
    add("ev_restore", 1,0,0,0,0, 1,4'hA,1);
    add("ev_idle",    1,0,0,0,0, 0,4'hA,0);
    // simultaneous strobes
    add("both_wr", 1,1,4'h3,1,4'hC, 1,4'hC,1);
    repeat (H) add("both_hold", 1,0,0,0,0, 0,4'hC,1);
    add("both_restore", 1,0,0,0,0, 1,4'h3,1);
    add("both_no_wrsw", 1,0,0,0,0, 0,4'h3,0);
    // retrigger in 3rd hold cycle
    add("rt_wr1", 1,0,0,1,4'h1, 1,4'h1,1);
    repeat (3) add("rt_hold1", 1,0,0,0,0, 0,4'h1,1);
    add("rt_wr2", 1,0,0,1,4'h2, 1,4'h2,1);
    repeat (H) add("rt_hold2", 1,0,0,0,0, 0,4'h2,1);
    add("rt_restore", 1,0,0,0,0, 1,4'h3,1);
    add("rt_idle",    1,0,0,0,0, 0,4'h3,0);
    // software request during hold
    add("swh_ev",   1,0,0,1,4'h9, 1,4'h9,1);
    add("swh_h1",   1,0,0,0,0,    0,4'h9,1);
    add("swh_sw",   1,1,4'h7,0,0, 0,4'h9,1);
    repeat (2) add("swh_hold", 1,0,0,0,0, 0,4'h9,1);
    add("swh_restore", 1,0,0,0,0, 1,4'h7,1);
    repeat (2) add("swh_no_wrsw", 1,0,0,0,0, 0,4'h7,0);
    // reset during hold
    add("rh_ev",   1,0,0,1,4'h6, 1,4'h6,1);
    add("rh_hold", 1,0,0,0,0,    0,4'h6,1);
    add("rh_rst",  0,0,0,0,0,    0,0,0);
    repeat (6) add("rh_after", 1,0,0,0,0, 0,0,0);
    // sw_req landing in the WR_SW cycle keeps pending
    add("sws_wr1", 1,1,4'h1,0,0, 1,4'h1,1);
    add("sws_wr2", 1,1,4'h2,0,0, 1,4'h2,1);
    add("sws_idle",1,0,0,0,0,    0,4'h2,0);
    // back-to-back events
    add("bb_ev1", 1,0,0,1,4'h4, 1,4'h4,1);
    add("bb_ev2", 1,0,0,1,4'h8, 1,4'h8,1);
    repeat (H) add("bb_hold", 1,0,0,0,0, 0,4'h8,1);
    add("bb_restore", 1,0,0,0,0, 1,4'h2,1);
    add("bb_idle",    1,0,0,0,0, 0,4'h2,0);

    @(negedge clk);
    foreach (tbl[i])
      step(tbl[i].name, tbl[i].rst_n, tbl[i].swr, tbl[i].swd, tbl[i].evr, tbl[i].evd,
           tbl[i].cs, tbl[i].shw, tbl[i].bsy);

    // randomized run against the model, starting from reset
    model(0, 0, 0, 0, 0, c, s, b);
    step("rnd_reset", 0, 0, 0, 0, 0, c, s, b);
    for (int k = 0; k < 3000; k++) begin
      r  = ($urandom_range(0, 199) != 0);
      sr = ($urandom_range(0, 6) == 0);
      er = ($urandom_range(0, 9) == 0);
      sd = 4'($urandom_range(0, 15));
      ed = 4'($urandom_range(0, 15));
      model(r, sr, sd, er, ed, c, s, b);
      step("rnd", r, sr, sd, er, ed, c, s, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
